pc_branch_unit: RTL and testbench

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_unit_if.sv | 43 ++++
 rtl/pc_branch_unit.sv | 109 ++++++++++
 tb/tb_pc_branch_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_branch_unit_if.sv
// Control-flow bundle between the decode/execute stage and the PC/branch unit.
// Carries the comparator flags, branch/jump controls, operands and the PC/trap results.
// master: the stage supplying controls and consuming the PC; slave: pc_branch_unit.
interface pc_branch_unit_if #(
  parameter int DATA_W = 32
);
  // comparator flags for the current instruction
  logic              EQ;
  logic              NE;
  logic              LT;
  logic              LTU;
  logic              GE;
  logic              GEU;
  // branch / jump controls and operands
  logic              BranchControl;
  logic [2:0]        PCBranchType;
  logic [1:0]        JumpType;
  logic [DATA_W-1:0] BranchOffset;
  logic [DATA_W-1:0] JumpBase;
  logic              Stall;
  logic              TrapReturn;
  // results
  logic [DATA_W-1:0] ProgAddr;
  logic [DATA_W-1:0] LinkAddr;
  logic              Taken;
  logic              MisalignTrap;
  logic [DATA_W-1:0] BadAddr;
  logic [DATA_W-1:0] EPC;

  modport master (
    output EQ, NE, LT, LTU, GE, GEU,
    output BranchControl, PCBranchType, JumpType, BranchOffset, JumpBase,
    output Stall, TrapReturn,
    input  ProgAddr, LinkAddr, Taken, MisalignTrap, BadAddr, EPC
  );

  modport slave (
    input  EQ, NE, LT, LTU, GE, GEU,
    input  BranchControl, PCBranchType, JumpType, BranchOffset, JumpBase,
    input  Stall, TrapReturn,
    output ProgAddr, LinkAddr, Taken, MisalignTrap, BadAddr, EPC
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter with conditional branch, JAL/JALR redirect, misaligned-target trap and trap return.
// Latency: ProgAddr/EPC/BadAddr/MisalignTrap update one clock after the controls; LinkAddr and Taken are combinational.
// Ports: clock, reset (sync, active-high), bus (slave side of pc_branch_unit_if). Stall freezes all state for the cycle.
module pc_branch_unit #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] TRAP_VECTOR  = DATA_W'(32'h100)
) (
  input  logic            clock,
  input  logic            reset,
  pc_branch_unit_if.slave bus
);

  // branch codes follow the RISC-V funct3 encoding; 3'b010/3'b011 are undefined
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNEQ = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] JT_JAL  = 2'b01;
  localparam logic [1:0] JT_JALR = 2'b10;

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  logic [DATA_W-1:0] pc_q,   pc_d;
  logic [DATA_W-1:0] epc_q,  epc_d;
  logic [DATA_W-1:0] bad_q,  bad_d;
  logic              trap_q, trap_d;

  logic              cond;
  logic              branch_taken;
  logic              is_jal;
  logic              is_jalr;
  logic              taken;
  logic              misalign;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] jalr_sum;
  logic [DATA_W-1:0] target;

  always_comb begin
    cond = 1'b0;
    case (bus.PCBranchType)
      BR_BEQ:  cond = bus.EQ;
      BR_BNEQ: cond = bus.NE;
      BR_BLT:  cond = bus.LT;
      BR_BGE:  cond = bus.GE;
      BR_BLTU: cond = bus.LTU;
      BR_BGEU: cond = bus.GEU;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken = bus.BranchControl & cond;
  assign is_jal       = (bus.JumpType == JT_JAL);
  assign is_jalr      = (bus.JumpType == JT_JALR);
  // a jump always redirects, so it wins over any branch decision
  assign taken        = is_jal | is_jalr | branch_taken;

  assign pc_plus4 = pc_q + PC_STEP;
  assign jalr_sum = bus.JumpBase + bus.BranchOffset;
  assign target   = is_jalr ? {jalr_sum[DATA_W-1:1], 1'b0} : (pc_q + bus.BranchOffset);
  assign misalign = taken & (target[1:0] != 2'b00);

  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    bad_d  = bad_q;
    trap_d = 1'b0;
    if (!bus.Stall) begin
      if (bus.TrapReturn) begin
        // trap return wins over a faulting target; the saved context is kept
        pc_d = epc_q;
      end else if (misalign) begin
        pc_d   = TRAP_VECTOR;
        epc_d  = pc_q;
        bad_d  = target;
        trap_d = 1'b1;
      end else if (taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      epc_q  <= '0;
      bad_q  <= '0;
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      bad_q  <= bad_d;
      trap_q <= trap_d;
    end
  end

  assign bus.ProgAddr     = pc_q;
  assign bus.LinkAddr     = pc_plus4;
  assign bus.Taken        = taken;
  assign bus.MisalignTrap = trap_q;
  assign bus.BadAddr      = bad_q;
  assign bus.EPC          = epc_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a 32-bit instance and an 8-bit instance
// (RESET_VECTOR 0x20, TRAP_VECTOR 0x40) driven with hand-computed directed vectors.
module tb_pc_branch_unit;

  typedef struct packed {
    logic [15:0] id;
    logic [31:0] pc;
    logic [31:0] link;
    logic        taken;
    logic        trap;
    logic [31:0] epc;
    logic [31:0] bad;
  } exp_t;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNEQ = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;
  // flag vector order {EQ, NE, LT, LTU, GE, GEU}
  localparam logic [5:0] F_EQ  = 6'b100000;
  localparam logic [5:0] F_NE  = 6'b010000;
  localparam logic [5:0] F_LT  = 6'b001000;
  localparam logic [5:0] F_LTU = 6'b000100;
  localparam logic [5:0] F_GE  = 6'b000010;
  localparam logic [5:0] F_GEU = 6'b000001;
  localparam logic [1:0] J_NO   = 2'b00;
  localparam logic [1:0] J_JAL  = 2'b01;
  localparam logic [1:0] J_JALR = 2'b10;
  localparam logic [1:0] J_RSV  = 2'b11;

  logic clock = 1'b0;
  logic rst32 = 1'b1;
  logic rst8  = 1'b1;

  always #5 clock = ~clock;

  pc_branch_unit_if #(.DATA_W(32)) if32 ();
  pc_branch_unit_if #(.DATA_W(8))  if8 ();

  pc_branch_unit #(.DATA_W(32)) dut32 (
    .clock (clock),
    .reset (rst32),
    .bus   (if32.slave)
  );

  pc_branch_unit #(.DATA_W(8), .RESET_VECTOR(8'h20), .TRAP_VECTOR(8'h40)) dut8 (
    .clock (clock),
    .reset (rst8),
    .bus   (if8.slave)
  );

  exp_t q32[$];
  exp_t q8[$];
  int   total  = 0;
  int   passed = 0;
  int   vec32  = 0;
  int   vec8   = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
  endtask

  // one cycle on the 32-bit unit: controls for this cycle and outputs expected during it
  task automatic step32(input logic rst, input logic st, input logic tr, input logic bc,
                        input logic [2:0] bt, input logic [1:0] jt, input logic [5:0] fl,
                        input logic [31:0] off, input logic [31:0] base,
                        input logic [31:0] e_pc, input logic e_taken, input logic e_trap,
                        input logic [31:0] e_epc, input logic [31:0] e_bad);
    exp_t e;
    @(posedge clock);
    #1;
    rst32 = rst;
    if32.Stall = st;
    if32.TrapReturn = tr;
    if32.BranchControl = bc;
    if32.PCBranchType = bt;
    if32.JumpType = jt;
    {if32.EQ, if32.NE, if32.LT, if32.LTU, if32.GE, if32.GEU} = fl;
    if32.BranchOffset = off;
    if32.JumpBase = base;
    e.id = 16'(vec32);
    e.pc = e_pc;
    e.link = e_pc + 32'd4;
    e.taken = e_taken;
    e.trap = e_trap;
    e.epc = e_epc;
    e.bad = e_bad;
    q32.push_back(e);
    vec32++;
  endtask

  task automatic step8(input logic rst, input logic st, input logic tr, input logic [1:0] jt,
                       input logic [7:0] off, input logic [7:0] e_pc, input logic e_taken,
                       input logic e_trap, input logic [7:0] e_epc, input logic [7:0] e_bad);
    exp_t e;
    logic [7:0] lk;
    @(posedge clock);
    #1;
    rst8 = rst;
    if8.Stall = st;
    if8.TrapReturn = tr;
    if8.JumpType = jt;
    if8.BranchOffset = off;
    lk = e_pc + 8'd4;
    e.id = 16'(vec8);
    e.pc = {24'd0, e_pc};
    e.link = {24'd0, lk};
    e.taken = e_taken;
    e.trap = e_trap;
    e.epc = {24'd0, e_epc};
    e.bad = {24'd0, e_bad};
    q8.push_back(e);
    vec8++;
  endtask

  // monitors: compare whatever expectation is pending, mid-cycle
  always @(negedge clock) begin
    if (q32.size() > 0) begin
      exp_t e;
      e = q32.pop_front();
      chk("w32_pc",    int'(e.id), if32.ProgAddr, e.pc);
      chk("w32_link",  int'(e.id), if32.LinkAddr, e.link);
      chk("w32_taken", int'(e.id), {31'd0, if32.Taken}, {31'd0, e.taken});
      chk("w32_trap",  int'(e.id), {31'd0, if32.MisalignTrap}, {31'd0, e.trap});
      chk("w32_epc",   int'(e.id), if32.EPC, e.epc);
      chk("w32_bad",   int'(e.id), if32.BadAddr, e.bad);
    end
  end

  always @(negedge clock) begin
    if (q8.size() > 0) begin
      exp_t e;
      e = q8.pop_front();
      chk("w8_pc",    int'(e.id), {24'd0, if8.ProgAddr}, e.pc);
      chk("w8_link",  int'(e.id), {24'd0, if8.LinkAddr}, e.link);
      chk("w8_taken", int'(e.id), {31'd0, if8.Taken}, {31'd0, e.taken});
      chk("w8_trap",  int'(e.id), {31'd0, if8.MisalignTrap}, {31'd0, e.trap});
      chk("w8_epc",   int'(e.id), {24'd0, if8.EPC}, e.epc);
      chk("w8_bad",   int'(e.id), {24'd0, if8.BadAddr}, e.bad);
    end
  end

  initial begin
    {if32.EQ, if32.NE, if32.LT, if32.LTU, if32.GE, if32.GEU} = '0;
    if32.BranchControl = 1'b0; if32.PCBranchType = '0; if32.JumpType = '0;
    if32.BranchOffset = '0; if32.JumpBase = '0; if32.Stall = 1'b0; if32.TrapReturn = 1'b0;
    {if8.EQ, if8.NE, if8.LT, if8.LTU, if8.GE, if8.GEU} = '0;
    if8.BranchControl = 1'b0; if8.PCBranchType = '0; if8.JumpType = '0;
    if8.BranchOffset = '0; if8.JumpBase = '0; if8.Stall = 1'b0; if8.TrapReturn = 1'b0;

    @(posedge clock);
    //     rst st tr bc bt    jt      flags      off            base           pc            tk tp epc       bad
    step32(0, 0, 0, 0, BEQ,  J_NO,   '0,        32'd0,         32'd0,         32'h0,        0, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_NO,   '0,        32'd0,         32'd0,         32'h4,        0, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_NO,   '0,        32'd0,         32'd0,         32'h8,        0, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BEQ,  J_NO,   F_EQ,      32'd40,        32'd0,         32'd12,       1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_JALR, '0,        32'd1,         32'h203,       32'd52,       1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_JAL,  '0,        -32'sd8,       32'd0,         32'h204,      1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BEQ,  J_NO,   6'b011111, 32'd40,        32'd0,         32'h1FC,      0, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BEQ,  J_JAL,  '0,        32'h10,        32'd0,         32'h200,      1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_JAL,  '0,        -32'sh1F0,     32'd0,         32'h210,      1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BGEU, J_NO,   F_GEU,     32'd6,         32'd0,         32'h20,       1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_NO,   '0,        32'd0,         32'd0,         32'h100,      0, 1, 32'h20, 32'h26);
    step32(0, 0, 1, 0, BEQ,  J_JAL,  '0,        32'd2,         32'd0,         32'h104,      1, 0, 32'h20, 32'h26);
    step32(0, 1, 0, 1, BEQ,  J_NO,   F_EQ,      32'h40,        32'd0,         32'h20,       1, 0, 32'h20, 32'h26);
    step32(0, 1, 0, 1, BEQ,  J_NO,   F_EQ,      32'h40,        32'd0,         32'h20,       1, 0, 32'h20, 32'h26);
    step32(0, 0, 0, 1, BEQ,  J_NO,   F_EQ,      32'h40,        32'd0,         32'h20,       1, 0, 32'h20, 32'h26);
    step32(0, 1, 1, 0, BEQ,  J_JAL,  '0,        32'd2,         32'd0,         32'h60,       1, 0, 32'h20, 32'h26);
    step32(0, 0, 0, 0, BEQ,  J_JAL,  '0,        32'd2,         32'd0,         32'h60,       1, 0, 32'h20, 32'h26);
    step32(1, 1, 1, 0, BEQ,  J_JAL,  '0,        32'd2,         32'd0,         32'h100,      1, 1, 32'h60, 32'h62);
    step32(0, 0, 0, 1, 3'b010, J_NO, 6'b111111, 32'd8,         32'd0,         32'h0,        0, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_RSV,  '0,        32'd8,         32'd0,         32'h4,        0, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BLT,  J_NO,   F_LT,      -32'sd8,       32'd0,         32'h8,        1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BNEQ, J_NO,   F_NE,      32'h10,        32'd0,         32'h0,        1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BLTU, J_NO,   F_LTU,     32'h30,        32'd0,         32'h10,       1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BGE,  J_NO,   F_GE,      32'd4,         32'd0,         32'h40,       1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 1, BGE,  J_NO,   6'b111101, 32'd4,         32'd0,         32'h44,       0, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_JALR, '0,        32'hC,         32'hFFFF_FFF0, 32'h48,       1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_NO,   '0,        32'd0,         32'd0,         32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0);
    step32(0, 0, 0, 0, BEQ,  J_JALR, '0,        32'h10,        32'h31,        32'h0,        1, 0, 32'h0,  32'h0);
    step32(0, 0, 0, 0, BEQ,  J_NO,   '0,        32'd0,         32'd0,         32'h40,       0, 0, 32'h0,  32'h0);

    //    rst st tr jt     off    pc     tk tp epc    bad
    step8(0, 0, 0, J_JAL, 8'hDC, 8'h20, 1, 0, 8'h00, 8'h00);
    step8(0, 0, 0, J_NO,  8'h00, 8'hFC, 0, 0, 8'h00, 8'h00);
    step8(1, 1, 0, J_JAL, 8'h08, 8'h00, 1, 0, 8'h00, 8'h00);
    step8(0, 0, 0, J_JAL, 8'h01, 8'h20, 1, 0, 8'h00, 8'h00);
    step8(0, 0, 1, J_NO,  8'h00, 8'h40, 0, 1, 8'h20, 8'h21);
    step8(0, 0, 0, J_NO,  8'h00, 8'h20, 0, 0, 8'h20, 8'h21);

    repeat (3) @(negedge clock);
    total++;
    if (q32.size() == 0 && q8.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q32.size(), q8.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
